// File: rtl/ahb_slave_regfile.sv
// ---------------------------------------------------------------------------
// ahb_slave_regfile
//
// AHB-Lite slave exposing NUM_REGS word registers, with an optional fixed
// number of data-phase wait states per transfer.
//
// The register index is HADDR[6:2], so the array holds at most 32 words.
// A transfer is legal when its index is below NUM_REGS and HSIZE is 3'b010.
// Byte offset HADDR[1:0], HBURST and HPROT are ignored.
//
// Build option:
//   AHB_REGFILE_ERROR_RESP_EN  defined   -> illegal transfers get a two-cycle
//                                           ERROR response (ERR1, ERR2).
//                              undefined -> illegal transfers use normal
//                                           OKAY timing; writes are dropped
//                                           and reads return zero.
//
// Parameters:
//   ADDRESSWIDTH  HADDR width (must be at least 8)
//   DATAWIDTH     data and register width
//   NUM_REGS      number of implemented registers, 1..32
//   WAIT_STATES   data-phase wait cycles per transfer, 0..15
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   synchronous active-low reset
//   HSEL      in   slave select
//   HADDR     in   byte address
//   HWRITE    in   1 = write, 0 = read
//   HTRANS    in   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HSIZE     in   transfer size, only word (010) is legal
//   HBURST    in   ignored
//   HPROT     in   ignored
//   HWDATA    in   write data, valid in the data phase
//   HREADYIN  in   bus ready, gates address-phase sampling
//   HREADY    out  slave ready, low stalls the data phase
//   HRESP     out  00 OKAY, 01 ERROR
//   HRDATA    out  read data, zero except in the final read data cycle
// ---------------------------------------------------------------------------
module ahb_slave_regfile #(
    parameter int ADDRESSWIDTH = 32,
    parameter int DATAWIDTH    = 32,
    parameter int NUM_REGS     = 32,
    parameter int WAIT_STATES  = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    HSEL,
    input  logic [ADDRESSWIDTH-1:0] HADDR,
    input  logic                    HWRITE,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic [DATAWIDTH-1:0]    HWDATA,
    input  logic                    HREADYIN,
    output logic                    HREADY,
    output logic [1:0]              HRESP,
    output logic [DATAWIDTH-1:0]    HRDATA
);

    localparam int         MAX_REGS   = 32;
    localparam logic [5:0] NUM_REGS_L = 6'(NUM_REGS);
    localparam bit         USE_WAIT   = (WAIT_STATES > 0);
    // Counter load value: WAIT exits when the count reaches zero, so loading
    // WAIT_STATES-1 yields exactly WAIT_STATES stalled cycles.
    localparam logic [3:0] WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

`ifdef AHB_REGFILE_ERROR_RESP_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DONE = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DONE = 3'd2
    } state_t;
`endif

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           wait_cnt_q;
    logic [3:0]           wait_cnt_d;

    logic                 can_accept;
    logic                 accept_p0;
    logic [4:0]           idx_p0;
    logic                 legal_p0;

    logic [4:0]           idx_p1;
    logic                 write_p1;
    logic                 legal_p1;
    logic                 commit_p1;

    logic [DATAWIDTH-1:0] regs [0:MAX_REGS-1];

    logic                 unused_inputs;
    assign unused_inputs = ^{HADDR[ADDRESSWIDTH-1:7], HADDR[1:0], HTRANS[0], HBURST, HPROT};

    // ---- Address phase (p0) ------------------------------------------------
    // New address phases are only taken while this slave is driving HREADY
    // high, i.e. in the states that can overlap the next address phase.
    always_comb begin
        can_accept = 1'b0;
        case (state_q)
            IDLE:    can_accept = 1'b1;
            DONE:    can_accept = 1'b1;
`ifdef AHB_REGFILE_ERROR_RESP_EN
            ERR2:    can_accept = 1'b1;
`endif
            default: can_accept = 1'b0;
        endcase
    end

    assign accept_p0 = can_accept && HSEL && HREADYIN && HTRANS[1];
    assign idx_p0    = HADDR[6:2];
    assign legal_p0  = ({1'b0, idx_p0} < NUM_REGS_L) && (HSIZE == 3'b010);

    // ---- FSM next state ----------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
`ifdef AHB_REGFILE_ERROR_RESP_EN
            ERR1: begin
                state_d = ERR2;
            end
`endif
            default: begin
                // IDLE, DONE and ERR2 share the same acceptance rule.
                if (accept_p0) begin
`ifdef AHB_REGFILE_ERROR_RESP_EN
                    if (!legal_p0) begin
                        state_d = ERR1;
                    end else if (USE_WAIT) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = DONE;
                    end
`else
                    if (USE_WAIT) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = DONE;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // ---- Data phase (p1) ---------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            idx_p1     <= 5'd0;
            write_p1   <= 1'b0;
            legal_p1   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept_p0) begin
                idx_p1   <= idx_p0;
                write_p1 <= HWRITE;
                legal_p1 <= legal_p0;
            end
        end
    end

    // Illegal transfers can only reach DONE when error responses are not
    // built in; the legality flag then drops the write.
    assign commit_p1 = (state_q == DONE) && write_p1 && legal_p1;

    // Entries at or above NUM_REGS are never written and stay zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_p1) begin
            regs[idx_p1] <= HWDATA;
        end
    end

    // Outputs are forced to their idle values while reset is held so the bus
    // sees a quiet slave even before the first reset edge.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        HRDATA = '0;
        if (reset_n) begin
            case (state_q)
                WAIT: begin
                    HREADY = 1'b0;
                end
                DONE: begin
                    if (!write_p1 && legal_p1) begin
                        HRDATA = regs[idx_p1];
                    end
                end
`ifdef AHB_REGFILE_ERROR_RESP_EN
                ERR1: begin
                    HREADY = 1'b0;
                    HRESP  = RESP_ERROR;
                end
                ERR2: begin
                    HRESP = RESP_ERROR;
                end
`endif
                default: begin
                    HREADY = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_regfile
//
// Bench for ahb_slave_regfile with NUM_REGS=16 and WAIT_STATES=2. Works with
// and without AHB_REGFILE_ERROR_RESP_EN defined. A transaction-level model
// (word array plus the one transfer in its data phase) predicts HREADY,
// HRESP and HRDATA every cycle; directed transfers also pin literal values.
// ---------------------------------------------------------------------------
module tb_ahb_slave_regfile;

    localparam int NR = 16;
    localparam int WS = 2;
`ifdef AHB_REGFILE_ERROR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    always #5 clk = ~clk;

    ahb_slave_regfile #(
        .ADDRESSWIDTH(32),
        .DATAWIDTH   (32),
        .NUM_REGS    (NR),
        .WAIT_STATES (WS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .HSEL    (HSEL),
        .HADDR   (HADDR),
        .HWRITE  (HWRITE),
        .HTRANS  (HTRANS),
        .HSIZE   (HSIZE),
        .HBURST  (HBURST),
        .HPROT   (HPROT),
        .HWDATA  (HWDATA),
        .HREADYIN(HREADYIN),
        .HREADY  (HREADY),
        .HRESP   (HRESP),
        .HRDATA  (HRDATA)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: register contents plus the transfer currently in its data phase.
    // m_left counts the data-phase cycles still to go, including this one.
    logic [31:0] mem [0:NR-1];
    bit          m_busy;
    int          m_left;
    bit          m_write;
    bit          m_legal;
    bit          m_err;
    logic [4:0]  m_idx;

    function automatic logic exp_ready();
        if (!reset_n || !m_busy) return 1'b1;
        return (m_left == 1);
    endfunction

    function automatic logic [1:0] exp_resp();
        if (!reset_n || !m_busy) return 2'b00;
        return m_err ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (!reset_n || !m_busy) return 32'h0;
        if (m_left == 1 && !m_write && m_legal && !m_err) return mem[m_idx[3:0]];
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("hready", 32'(HREADY), 32'(exp_ready()));
        chk("hresp",  32'(HRESP),  32'(exp_resp()));
        chk("hrdata", HRDATA,      exp_rdata());
    endtask

    // Advance the model across one rising edge using the inputs on the bus.
    task automatic model_step();
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) mem[i] = 32'h0;
            m_busy = 1'b0;
            m_left = 0;
        end else if (m_busy && m_left > 1) begin
            m_left = m_left - 1;
        end else begin
            if (m_busy && m_write && m_legal && !m_err) mem[m_idx[3:0]] = HWDATA;
            if (HSEL && HREADYIN && HTRANS[1]) begin
                m_busy  = 1'b1;
                m_idx   = HADDR[6:2];
                m_write = HWRITE;
                m_legal = (int'(HADDR[6:2]) < NR) && (HSIZE == 3'b010);
                m_err   = ERR_EN && !m_legal;
                m_left  = m_err ? 2 : WS + 1;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, then check the
    // outputs of the following cycle at the next falling edge.
    task automatic tick(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic wr, input logic [2:0] size, input logic rstn,
                        input logic rdy_low);
        reset_n  = rstn;
        HSEL     = sel;
        HTRANS   = trans;
        HADDR    = addr;
        HWRITE   = wr;
        HSIZE    = size;
        HBURST   = 3'($urandom);
        HPROT    = 4'($urandom);
        HREADYIN = (m_busy ? (m_left == 1) : 1'b1) && !rdy_low;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_tick();
        tick(1'b1, 2'b00, 32'h0, 1'b0, 3'b010, 1'b1, 1'b0);
    endtask

    // One transfer; returns in the final data cycle (HREADY high) before it
    // completes, so a following call overlaps its address phase with it.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wd, output logic [31:0] rdata,
                           output logic [1:0] resp_first, output logic [1:0] resp_last,
                           output int stalls);
        tick(1'b1, 2'b10, addr, wr, size, 1'b1, 1'b0);
        HWDATA     = wd;
        resp_first = HRESP;
        stalls     = 0;
        while (HREADY !== 1'b1 && stalls < 20) begin
            stalls++;
            idle_tick();
        end
        if (HREADY !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_timeout: HREADY=%b after %0d cycles, expected 1", HREADY, stalls);
        end
        rdata     = HRDATA;
        resp_last = HRESP;
    endtask

    logic [31:0] rd;
    logic [1:0]  r1;
    logic [1:0]  r2;
    int          st;

    initial begin
        reset_n  = 1'b0;
        HSEL     = 1'b0;
        HADDR    = 32'h0;
        HWRITE   = 1'b0;
        HTRANS   = 2'b00;
        HSIZE    = 3'b010;
        HBURST   = 3'b000;
        HPROT    = 4'h0;
        HWDATA   = 32'h0;
        HREADYIN = 1'b1;
        m_busy   = 1'b0;
        m_left   = 0;
        m_write  = 1'b0;
        m_legal  = 1'b0;
        m_err    = 1'b0;
        m_idx    = 5'd0;
        for (int i = 0; i < NR; i++) mem[i] = 32'h0;

        @(negedge clk);
        tick(1'b0, 2'b00, 32'h0, 1'b0, 3'b010, 1'b0, 1'b0);
        tick(1'b1, 2'b10, 32'h8, 1'b1, 3'b010, 1'b0, 1'b0);
        chk("rst_hready", 32'(HREADY), 32'h1);
        chk("rst_hresp",  32'(HRESP),  32'h0);
        chk("rst_hrdata", HRDATA,      32'h0);
        idle_tick();

        // Write then back-to-back read of the same word.
        do_xfer(1'b1, 32'h08, 3'b010, 32'hDEADBEEF, rd, r1, r2, st);
        chk("wr08_stalls", 32'(st), 32'd2);
        chk("wr08_resp",   32'(r2), 32'h0);
        do_xfer(1'b0, 32'h08, 3'b010, 32'h0, rd, r1, r2, st);
        chk("rd08_data",   rd,      32'hDEADBEEF);
        chk("rd08_stalls", 32'(st), 32'd2);

        do_xfer(1'b0, 32'h04, 3'b010, 32'h0, rd, r1, r2, st);
        chk("rd04_data",   rd,      32'h0);
        chk("rd04_stalls", 32'(st), 32'd2);

        // Out-of-range index 16.
        do_xfer(1'b1, 32'h40, 3'b010, 32'hCAFEF00D, rd, r1, r2, st);
        chk("wr40_stalls",     32'(st), ERR_EN ? 32'd1 : 32'd2);
        chk("wr40_resp_first", 32'(r1), ERR_EN ? 32'h1 : 32'h0);
        chk("wr40_resp_last",  32'(r2), ERR_EN ? 32'h1 : 32'h0);
        do_xfer(1'b0, 32'h40, 3'b010, 32'h0, rd, r1, r2, st);
        chk("rd40_data", rd,      32'h0);
        chk("rd40_resp", 32'(r2), ERR_EN ? 32'h1 : 32'h0);
        do_xfer(1'b0, 32'h08, 3'b010, 32'h0, rd, r1, r2, st);
        chk("rd08_after_err_data", rd,      32'hDEADBEEF);
        chk("rd08_after_err_resp", 32'(r2), 32'h0);

        // Halfword size is illegal even for an in-range index.
        do_xfer(1'b1, 32'h10, 3'b001, 32'h11111111, rd, r1, r2, st);
        do_xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, r1, r2, st);
        chk("rd10_after_bad_size", rd, 32'h0);

        // BUSY and IDLE with HSEL high, HSEL low and HREADYIN low are no-ops.
        do_xfer(1'b1, 32'h17, 3'b010, 32'hA5A50F0F, rd, r1, r2, st);
        tick(1'b1, 2'b01, 32'h14, 1'b1, 3'b010, 1'b1, 1'b0);
        chk("busy_hready", 32'(HREADY), 32'h1);
        chk("busy_hresp",  32'(HRESP),  32'h0);
        HWDATA = 32'hFFFFFFFF;
        tick(1'b1, 2'b00, 32'h14, 1'b1, 3'b010, 1'b1, 1'b0);
        chk("idle_hready", 32'(HREADY), 32'h1);
        tick(1'b0, 2'b10, 32'h14, 1'b1, 3'b010, 1'b1, 1'b0);
        chk("nosel_hready", 32'(HREADY), 32'h1);
        tick(1'b1, 2'b10, 32'h14, 1'b1, 3'b010, 1'b1, 1'b1);
        chk("noready_hready", 32'(HREADY), 32'h1);
        idle_tick();
        do_xfer(1'b0, 32'h14, 3'b010, 32'h0, rd, r1, r2, st);
        chk("rd14_data", rd, 32'hA5A50F0F);

        // Reset during a write's wait cycle discards the write.
        tick(1'b1, 2'b10, 32'h0C, 1'b1, 3'b010, 1'b1, 1'b0);
        HWDATA = 32'h12345678;
        chk("wr0c_wait_hready", 32'(HREADY), 32'h0);
        tick(1'b1, 2'b00, 32'h0, 1'b0, 3'b010, 1'b0, 1'b0);
        chk("rst_mid_hready", 32'(HREADY), 32'h1);
        chk("rst_mid_hresp",  32'(HRESP),  32'h0);
        idle_tick();
        idle_tick();
        do_xfer(1'b0, 32'h0C, 3'b010, 32'h0, rd, r1, r2, st);
        chk("rd0c_after_rst", rd, 32'h0);
        do_xfer(1'b0, 32'h08, 3'b010, 32'h0, rd, r1, r2, st);
        chk("rd08_after_rst", rd, 32'h0);

        // Random traffic; inputs keep changing during stalls on purpose.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            a        = $urandom;
            a[6:2]   = 5'($urandom_range(0, 19));
            sz       = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010;
            tick(($urandom_range(0, 3) != 0), 2'($urandom), a, 1'($urandom), sz,
                 ($urandom_range(0, 299) != 0), ($urandom_range(0, 9) == 0));
            HWDATA = $urandom;
        end
        idle_tick();
        idle_tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
